dmem_bridge: RTL
================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, bus address width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have port mem_en_i  in  1  MEM-stage instruction is a load/store.
REQ-005 SHALL have port mem_type_i  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
REQ-006 SHALL have port addr_i  in  32  effective address (EXResultM).
REQ-007 SHALL have port wdata_i  in  32  store data (WriteDataM).
REQ-008 SHALL have port advance_i  in  1  pipeline moves MEM->WB this cycle.
REQ-009 SHALL have port rdata_o  out  32  aligned, extended load data (ReadDataM).
REQ-010 SHALL have port stall_o  out  1  MEM access incomplete; hazard unit stalls F/D/E/M.
REQ-011 SHALL have ports data_req_o 1, data_wr_o 1, data_size_o 2, data_addr_o 32, data_wdata_o 32, data_wstrb_o 4 (out), data_addr_ok_i 1, data_data_ok_i 1, data_rdata_i 32 (in): SRAM-like data bus.
REQ-012 SHALL have ports adel_o  out  1 and ades_o  out  1: load/store address error.

Function
REQ-013 SHALL implement states IDLE, ADDR, DATA, DONE.
REQ-014 IDLE: data_req_o = mem_en_i & ~misaligned; if data_addr_ok_i also high, go DATA, else if request raised go ADDR.
REQ-015 ADDR: data_req_o held high with stable addr/size/wdata/wstrb until data_addr_ok_i; then DATA.
REQ-016 DATA: data_req_o low; data_data_ok_i ignored outside DATA; on data_data_ok_i capture data_rdata_i, go DONE.
REQ-017 DONE: no new request; on advance_i go IDLE; access never reissued while in DONE.
REQ-018 stall_o SHALL equal mem_en_i & ~misaligned & (state != DONE); zero cycles of stall impossible (minimum 2 cycles IDLE->DATA->DONE).
REQ-019 data_size_o: byte 0, half 1, word 2; data_wr_o = mem_type_i[2:0] >= 5.
REQ-020 Stores: SB wdata = {4{wdata_i[7:0]}}, wstrb = 1<<addr[1:0]; SH wdata = {2{wdata_i[15:0]}}, wstrb = addr[1] ? 1100 : 0011; SW wstrb 1111.
REQ-021 Loads: rdata_o selects byte/half of captured word by addr_i[1:0], sign-extends for LB/LH, zero-extends for LBU/LHU; stores return 0.
REQ-022 data_addr_o = addr_i with low 2 bits cleared.

Reset
REQ-023 rst low at any clock edge, including mid-transaction, SHALL force IDLE, captured word 0, data_req_o 0, stall_o 0; a pending bus data_ok after reset is ignored.

Configuration
REQ-024 With MISALIGN_EXC_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned; no bus request, stall_o 0, adel_o (load) or ades_o (store) high combinationally while mem_en_i.
REQ-025 Without MISALIGN_EXC_EN: misaligned is constant 0, adel_o/ades_o tied 0, half uses addr[1] only, word ignores addr[1:0].

Structure
REQ-026 Package mycpu_pkg SHALL hold mem_type encodings, data_size codes and the state enum.
REQ-027 Load alignment/extension SHALL be sub-module load_extend (combinational); FSM and store path stay in dmem_bridge.

Verification
REQ-028 LW addr 0x100, addr_ok same cycle, data_ok 3 cycles later rdata 0x12345678 -> stall_o 4 cycles, rdata_o 0x12345678.
REQ-029 LB addr 0x103, data 0x80FFFFFF -> rdata_o 0xFFFFFF80; LBU -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
REQ-030 SH addr 0x202 wdata 0xAAAABEEF -> wdata 0xBEEFBEEF, wstrb 1100, size 1, addr 0x200.
REQ-031 addr_ok withheld 5 cycles -> req and all bus fields stable 5 cycles; advance_i low in DONE 2 cycles -> no second req.
REQ-032 rst low while in DATA, then data_ok -> state IDLE, no capture, stall_o 0.
REQ-033 MISALIGN_EXC_EN, LW addr 0x101 -> adel_o 1, data_req_o 0, stall_o 0; undefined -> aligned request to 0x100.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared encodings for the MEM-stage data bridge: access types, bus size codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mycpu_pkg;

   // mem_type encodings as decoded in the MEM stage
   localparam logic [2:0] MT_LB  = 3'd0;
   localparam logic [2:0] MT_LBU = 3'd1;
   localparam logic [2:0] MT_LH  = 3'd2;
   localparam logic [2:0] MT_LHU = 3'd3;
   localparam logic [2:0] MT_LW  = 3'd4;
   localparam logic [2:0] MT_SB  = 3'd5;
   localparam logic [2:0] MT_SH  = 3'd6;
   localparam logic [2:0] MT_SW  = 3'd7;

   // SRAM-like bus size codes
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_store(input logic [2:0] mt);
      return mt >= MT_SB;
   endfunction

   function automatic logic [1:0] size_of(input logic [2:0] mt);
      case (mt)
         MT_LB, MT_LBU, MT_SB: return SZ_BYTE;
         MT_LH, MT_LHU, MT_SH: return SZ_HALF;
         default:              return SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a fetched word and sign/zero-extends it for the load type.
// Latency: purely combinational.
// Backpressure: none; stores yield zero.
module load_extend
   import mycpu_pkg::*;
(
   input  logic [2:0]  mem_type,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the lane addressed by the low address bits; halves only look at bit 1
   always_comb begin
      byte_sel = 8'h00;
      case (byte_off)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = 8'h00;
      endcase
      half_sel = byte_off[1] ? word[31:16] : word[15:0];
   end

   // Extend according to the load flavour
   always_comb begin
      data = 32'h0;
      case (mem_type)
         MT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         MT_LBU:  data = {24'h0, byte_sel};
         MT_LH:   data = {{16{half_sel[15]}}, half_sel};
         MT_LHU:  data = {16'h0, half_sel};
         MT_LW:   data = word;
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage bridge to an SRAM-like data bus; optional misaligned-address exceptions via MISALIGN_EXC_EN.
// Latency: >=2 cycles of stall per access (IDLE->DATA->DONE), result held in DONE until advance_i.
// Backpressure: request held stable until data_addr_ok_i; pipeline stalled until data_data_ok_i.
module dmem_bridge
   import mycpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_en_i,
   input  logic [2:0]        mem_type_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic              advance_i,
   output logic [31:0]       rdata_o,
   output logic              stall_o,
   output logic              data_req_o,
   output logic              data_wr_o,
   output logic [1:0]        data_size_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [31:0]       data_wdata_o,
   output logic [3:0]        data_wstrb_o,
   input  logic              data_addr_ok_i,
   input  logic              data_data_ok_i,
   input  logic [31:0]       data_rdata_i,
   output logic              adel_o,
   output logic              ades_o
);

   state_t      state_q, state_d;
   logic [31:0] word_q;
   logic        misaligned;
   logic        access;
   logic        store;

   assign store = is_store(mem_type_i);

`ifdef MISALIGN_EXC_EN
   // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault
   always_comb begin
      misaligned = 1'b0;
      case (size_of(mem_type_i))
         SZ_HALF: misaligned = addr_i[0];
         SZ_WORD: misaligned = (addr_i[1:0] != 2'b00);
         default: misaligned = 1'b0;
      endcase
   end
   assign adel_o = mem_en_i & misaligned & ~store;
   assign ades_o = mem_en_i & misaligned &  store;
`else
   assign misaligned = 1'b0;
   assign adel_o     = 1'b0;
   assign ades_o     = 1'b0;
`endif

   assign access = mem_en_i & ~misaligned;

   // Outputs are gated by reset so nothing leaks onto the bus while held in reset
   assign data_req_o = rst & ((state_q == ST_ADDR) | ((state_q == ST_IDLE) & access));
   assign stall_o    = rst & access & (state_q != ST_DONE);

   assign data_wr_o   = store;
   assign data_size_o = size_of(mem_type_i);
   assign data_addr_o = {addr_i[ADDR_W-1:2], 2'b00};

   // Store lane replication and byte strobes; loads drive no strobes
   always_comb begin
      data_wdata_o = 32'h0;
      data_wstrb_o = 4'b0000;
      case (mem_type_i)
         MT_SB: begin
            data_wdata_o = {4{wdata_i[7:0]}};
            data_wstrb_o = 4'b0001 << addr_i[1:0];
         end
         MT_SH: begin
            data_wdata_o = {2{wdata_i[15:0]}};
            data_wstrb_o = addr_i[1] ? 4'b1100 : 4'b0011;
         end
         MT_SW: begin
            data_wdata_o = wdata_i;
            data_wstrb_o = 4'b1111;
         end
         default: begin
            data_wdata_o = 32'h0;
            data_wstrb_o = 4'b0000;
         end
      endcase
   end

   // Next-state: address handshake, then data handshake, then hold until the pipeline moves
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (access) state_d = data_addr_ok_i ? ST_DATA : ST_ADDR;
         ST_ADDR: if (data_addr_ok_i) state_d = ST_DATA;
         ST_DATA: if (data_data_ok_i) state_d = ST_DONE;
         ST_DONE: if (advance_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and captured read word; data_ok only counts while waiting in DATA
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         word_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_DATA) && data_data_ok_i) word_q <= data_rdata_i;
      end
   end

   load_extend u_load_extend (
      .mem_type (mem_type_i),
      .byte_off (addr_i[1:0]),
      .word     (word_q),
      .data     (rdata_o)
   );

endmodule
